// File: rtl/mutex_requester.sv
// Client side of the single-cycle lock handshake: requests the shared resource,
// holds it for a fixed window, and retries with a linearly growing backoff on timeout.
module mutex_requester #(
    parameter int HOLD_CYCLES  = 4,
    parameter int TIMEOUT      = 8,
    parameter int MAX_RETRY    = 3,
    parameter int BACKOFF_BASE = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           granted,
    output logic                           request,
    output logic                           busy,
    output logic                           in_critical,
    output logic                           done,
    output logic                           fail,
    output logic [$clog2(MAX_RETRY+1)-1:0] attempt,
    output logic                           err_spurious,
    output logic [1:0]                     dbg_state
);

    localparam int AW = $clog2(MAX_RETRY + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BW = $clog2(MAX_RETRY * BACKOFF_BASE + 1);

    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [AW-1:0] ATT_LAST  = AW'(MAX_RETRY);

    // Handshake: request stays high for the whole REQ dwell; a granted pulse
    // sampled on a rising edge while in REQ transfers ownership on that edge.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_BACKOFF = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [BW-1:0] backoff_cnt, backoff_n;
    logic [AW-1:0] attempt_n;
    logic [BW-1:0] backoff_load;

    // Full-width product so the largest backoff never wraps.
    assign backoff_load = BW'(attempt) * BW'(BACKOFF_BASE) - BW'(1);
    assign dbg_state    = state;

    always_comb begin
        state_n   = state;
        wait_n    = wait_cnt;
        hold_n    = hold_cnt;
        backoff_n = backoff_cnt;
        attempt_n = attempt;
        case (state)
            S_IDLE: begin
                // A start coinciding with the done/fail pulse belongs to the old job.
                if (start && !done && !fail) begin
                    state_n   = S_REQ;
                    attempt_n = AW'(1);
                    wait_n    = '0;
                end
            end
            S_REQ: begin
                if (granted) begin
                    state_n = S_HOLD;
                    hold_n  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    if (attempt == ATT_LAST) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n   = S_BACKOFF;
                        backoff_n = backoff_load;
                    end
                end else begin
                    wait_n = wait_cnt + WW'(1);
                end
            end
            S_BACKOFF: begin
                if (backoff_cnt == '0) begin
                    state_n   = S_REQ;
                    attempt_n = attempt + AW'(1);
                    wait_n    = '0;
                end else begin
                    backoff_n = backoff_cnt - BW'(1);
                end
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            hold_cnt     <= '0;
            backoff_cnt  <= '0;
            attempt      <= '0;
            request      <= 1'b0;
            busy         <= 1'b0;
            in_critical  <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            state        <= state_n;
            wait_cnt     <= wait_n;
            hold_cnt     <= hold_n;
            backoff_cnt  <= backoff_n;
            attempt      <= attempt_n;
            request      <= (state_n == S_REQ);
            busy         <= (state_n != S_IDLE);
            in_critical  <= (state_n == S_HOLD);
            done         <= (state == S_HOLD) && (state_n == S_IDLE);
            fail         <= (state == S_REQ) && (state_n == S_IDLE);
            err_spurious <= err_spurious | (granted && (state != S_REQ));
        end
    end

endmodule

// File: tb/tb_mutex_requester.sv
// Directed and randomized jobs for mutex_requester, checked cycle by cycle
// against an attempt-window timeline computed from the grant schedule.
module tb_mutex_requester;

    localparam int HC = 4;
    localparam int TO = 8;
    localparam int MR = 3;
    localparam int BB = 2;
    localparam int AW = $clog2(MR + 1);
    localparam int OW = 6 + AW;
    localparam int L  = 48;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          granted;
    logic          request;
    logic          busy;
    logic          in_critical;
    logic          done;
    logic          fail;
    logic [AW-1:0] attempt;
    logic          err_spurious;
    logic [1:0]    dbg_state;

    int vectors;
    int miscompares;

    // Per-job stimulus and expected timeline (index = cycle within job).
    bit gnt[L];
    bit st_drv[L];
    int e_st[L];     // 0 idle, 1 requesting, 2 backing off, 3 holding
    bit e_req[L];
    bit e_crit[L];
    bit e_busy[L];
    bit e_done[L];
    bit e_fail[L];
    int e_att[L];
    bit e_err[L+1];
    int prev_att;
    bit prev_err;

    mutex_requester #(
        .HOLD_CYCLES (HC),
        .TIMEOUT     (TO),
        .MAX_RETRY   (MR),
        .BACKOFF_BASE(BB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .granted     (granted),
        .request     (request),
        .busy        (busy),
        .in_critical (in_critical),
        .done        (done),
        .fail        (fail),
        .attempt     (attempt),
        .err_spurious(err_spurious),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] observed();
        return {request, in_critical, busy, done, fail, err_spurious, attempt};
    endfunction

    task automatic clear_job();
        for (int c = 0; c < L; c++) begin
            gnt[c]    = 1'b0;
            st_drv[c] = 1'b0;
        end
        st_drv[0] = 1'b1;
    endtask

    task automatic mark(input int c, input int st, input int n);
        e_st[c]   = st;
        e_req[c]  = (st == 1);
        e_crit[c] = (st == 3);
        e_busy[c] = 1'b1;
        e_att[c]  = n;
    endtask

    // Walk attempt windows: each REQ window is TO cycles; the first grant inside
    // it wins, otherwise back off n*BB cycles or fail after the last attempt.
    task automatic build_exp();
        int  t, n, g, fin_c;
        bit  found, fin;
        for (int c = 0; c < L; c++) begin
            e_st[c] = 0; e_req[c] = 0; e_crit[c] = 0; e_busy[c] = 0;
            e_done[c] = 0; e_fail[c] = 0; e_att[c] = prev_att;
        end
        t = 1; n = 1; fin = 0; fin_c = 0;
        while (!fin) begin
            found = 0; g = 0;
            for (int c = t; c < t + TO; c++)
                if (!found && gnt[c]) begin found = 1; g = c; end
            if (found) begin
                for (int c = t; c <= g; c++) mark(c, 1, n);
                for (int c = g + 1; c <= g + HC; c++) mark(c, 3, n);
                fin_c = g + HC + 1;
                e_done[fin_c] = 1;
                fin = 1;
            end else begin
                for (int c = t; c < t + TO; c++) mark(c, 1, n);
                if (n == MR) begin
                    fin_c = t + TO;
                    e_fail[fin_c] = 1;
                    fin = 1;
                end else begin
                    for (int c = t + TO; c < t + TO + n * BB; c++) mark(c, 2, n);
                    t = t + TO + n * BB;
                    n++;
                end
            end
        end
        for (int c = fin_c; c < L; c++) e_att[c] = n;
        e_err[0] = prev_err;
        for (int c = 0; c < L; c++)
            e_err[c+1] = e_err[c] | (gnt[c] && (e_st[c] != 1));
    endtask

    task automatic run_job(input int job, input int rst_at);
        bit aborted;
        aborted = 0;
        for (int c = 0; c < L && !aborted; c++) begin
            @(posedge clk);
            #1;
            start   = st_drv[c];
            granted = gnt[c];
            if (c == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check($sformatf("job%0d async_rst c%0d", job, c), observed(), '0);
                start   = 1'b0;
                granted = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check($sformatf("job%0d post_rst k%0d", job, k), observed(), '0);
                end
                prev_att = 0;
                prev_err = 0;
                aborted  = 1;
            end else begin
                @(negedge clk);
                check($sformatf("job%0d c%0d", job, c), observed(),
                      {e_req[c], e_crit[c], e_busy[c], e_done[c], e_fail[c], e_err[c], AW'(e_att[c])});
            end
        end
        start   = 1'b0;
        granted = 1'b0;
        if (!aborted) begin
            prev_att = e_att[L-1];
            prev_err = e_err[L];
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prev_att    = 0;
        prev_err    = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        granted = 1'b0;
        #3 check("reset_state", observed(), '0);
        #19 rst_n = 1'b1;

        // Grant from a single-cycle granter: one cycle after request rises.
        clear_job(); gnt[2] = 1; build_exp(); run_job(1, -1);
        // No grant at all: three windows, backoffs 2 and 4, then fail.
        clear_job(); build_exp(); run_job(2, -1);
        // Grant three cycles into attempt 2.
        clear_job(); gnt[14] = 1; build_exp(); run_job(3, -1);
        // Spurious grants in IDLE and during HOLD.
        clear_job(); gnt[0] = 1; gnt[2] = 1; gnt[4] = 1; build_exp(); run_job(4, -1);
        // Grant on the timeout edge of attempt 1; starts during HOLD and on done.
        clear_job(); gnt[8] = 1; st_drv[10] = 1; st_drv[13] = 1; build_exp(); run_job(5, -1);
        // Async reset mid-HOLD, then mid-BACKOFF, then a clean job.
        clear_job(); gnt[2] = 1; build_exp(); run_job(6, 4);
        clear_job(); build_exp(); run_job(7, 10);
        clear_job(); gnt[2] = 1; build_exp(); run_job(8, -1);

        for (int j = 0; j < 20; j++) begin
            clear_job();
            for (int c = 0; c < L; c++) gnt[c] = ($urandom_range(0, 9) == 0);
            build_exp();
            for (int c = 1; c < L; c++)
                if ((e_st[c] != 0 || e_done[c] || e_fail[c]) && $urandom_range(0, 3) == 0)
                    st_drv[c] = 1'b1;
            run_job(100 + j, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mutex_requester.md
Name: mutex_requester

Overview:
- Client-side counterpart to the single-cycle lock granter in the shared-resource path (e.g. VGA frame-buffer/pixel-ROM access).
- On a `start` pulse it raises `request` and waits for the granter's one-cycle `granted` pulse.
- It then owns the resource for a fixed critical-section window and reports `done`.
- If no grant arrives within a timeout it backs off and retries, reporting `fail` after a bounded number of attempts.

Parameters:
- HOLD_CYCLES, 4, cycles `in_critical` stays high per successful grant (>=1)
- TIMEOUT, 8, cycles spent in REQ without grant before an attempt is abandoned (>=1)
- MAX_RETRY, 3, total request attempts per start before failing (>=1)
- BACKOFF_BASE, 2, backoff unit in cycles; backoff after attempt n (1-based) = n*BACKOFF_BASE (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request pulse; sampled only in IDLE
- granted  in  1  grant pulse from granter
- request  out  1  lock request to granter
- busy  out  1  high in every state except IDLE
- in_critical  out  1  resource owned this cycle
- done  out  1  one-cycle pulse, critical section completed
- fail  out  1  one-cycle pulse, all attempts timed out
- attempt  out  $clog2(MAX_RETRY+1)  attempts used for current/last job (1-based once REQ is entered)
- err_spurious  out  1  sticky: `granted` seen outside REQ

Behaviour:
- Reset: async on rst_n low. state=IDLE, all outputs 0, all counters 0. Reset mid-operation drops `request` and `in_critical` immediately, with no done/fail.
- All outputs are registered and decoded from the next state/counters, so an output reflects a transition in the cycle right after the deciding edge.
- IDLE: request=0, busy=0. start=1 -> REQ; attempt<=1, wait_cnt<=0. Any other start is ignored.
- REQ: request=1, busy=1.
  - granted=1 at an edge -> HOLD; hold_cnt<=0; request low from that cycle.
  - Otherwise wait_cnt++. When wait_cnt reaches TIMEOUT-1 and the edge has no grant:
    - if attempt==MAX_RETRY -> IDLE with fail=1 for one cycle; attempt keeps its value.
    - else -> BACKOFF; backoff_cnt<=attempt*BACKOFF_BASE-1.
  - A grant on the same edge as timeout wins: go to HOLD.
- BACKOFF: request=0.
  - backoff_cnt decrements.
  - At 0 -> REQ; attempt++, wait_cnt<=0.
- HOLD: in_critical=1, request=0.
  - hold_cnt increments.
  - At HOLD_CYCLES-1 -> IDLE with done=1 for one cycle; in_critical low in that cycle.
- done and fail are mutually exclusive and never back-to-back for one job.
- start asserted in the same cycle as done/fail is ignored. The job begins only when start is sampled in IDLE, one cycle later at the earliest.
- err_spurious: set when granted=1 is sampled in any state other than REQ. It clears only on reset. The spurious grant never changes state.
- Request stays continuously high for the whole REQ dwell; it never toggles within an attempt.
- Counter widths come from $clog2 of their maximum value. The backoff product is computed at MAX_RETRY*BACKOFF_BASE width, with no truncation.

Test Plan:
- Paired with the single-cycle granter, defaults, start at edge 0:
  - request high cycles 1-2; granted high cycle 2.
  - in_critical high cycles 3-6; done pulse cycle 7.
  - busy low cycle 7, attempt=1, err_spurious=0.
- granted tied 0, defaults, start at edge 0:
  - three REQ windows of 8 cycles each, separated by backoffs of 2 and 4 cycles.
  - attempt steps 1->2->3; fail pulse exactly once; done never.
- No grant on attempt 1; granted pulsed 3 cycles into attempt 2 -> HOLD entered, done pulse, attempt=2, fail never.
- granted pulsed while in IDLE and again during HOLD -> err_spurious=1 and stays set; state sequence and done timing unchanged.
- Grant on the same edge as the timeout of attempt 1 -> HOLD, no BACKOFF. Start pulses during HOLD and on the done cycle are ignored: exactly one done.
- rst_n low asynchronously mid-HOLD, and again mid-BACKOFF:
  - request, in_critical, busy go 0 without waiting for a clock edge.
  - no done/fail; a new start after release completes normally.
